// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD request arbiter: FSM states, SD field
// widths and the default ISSUE-phase timeout.
package sd_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 2097152;
  localparam int LBA_W           = 32;
  localparam int BLKCNT_W        = 6;
  localparam int DATA_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Round-robin picker: returns the first active request after i_last,
// wrapping from NREQ-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);

  int w_cand;

  // Scan from i_last+1 upward; the first hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int off = 1; off <= NREQ; off++) begin
      w_cand = (int'(i_last) + off) % NREQ;
      if (!o_valid && i_req[IW'(w_cand)]) begin
        o_valid = 1'b1;
        o_idx   = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Multiplexes NREQ block requesters onto one SD channel. One transaction at a
// time: IDLE picks an owner, ISSUE waits for sd_ack (or times out), XFER
// follows the ack-high data phase, DONE pulses the owner's ack/err.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_rd,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [LBA_W-1:0]    req_lba      [NREQ],
  input  logic [BLKCNT_W-1:0] req_blk_cnt  [NREQ],
  input  logic [DATA_W-1:0]   req_buff_din [NREQ],
  output logic [NREQ-1:0]     req_buff_wr,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     req_err,
  output logic [LBA_W-1:0]    sd_lba,
  output logic [BLKCNT_W-1:0] sd_blk_cnt,
  output logic                sd_rd,
  output logic                sd_wr,
  input  logic                sd_ack,
  input  logic                sd_buff_wr,
  output logic [DATA_W-1:0]   sd_buff_din,
  output logic                busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);

  arb_state_t          r_state;
  logic [IW-1:0]       r_grant_id;
  logic [IW-1:0]       r_last_grant;
  logic [LBA_W-1:0]    r_sd_lba;
  logic [BLKCNT_W-1:0] r_sd_blk_cnt;
  logic                r_sd_rd;
  logic                r_sd_wr;
  logic [NREQ-1:0]     r_req_ack;
  logic [NREQ-1:0]     r_req_err;
  logic [31:0]         r_timeout_cnt;

  logic                w_pick_valid;
  logic [IW-1:0]       w_pick_idx;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req   (req_rd | req_wr),
    .i_last  (r_last_grant),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Transaction FSM; every channel output and completion pulse is registered.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values; blocking here would create races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant_id    <= '0;
      r_last_grant  <= IW'(NREQ - 1);
      r_sd_lba      <= '0;
      r_sd_blk_cnt  <= '0;
      r_sd_rd       <= 1'b0;
      r_sd_wr       <= 1'b0;
      r_req_ack     <= '0;
      r_req_err     <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_req_ack <= '0;
      r_req_err <= '0;
      case (r_state)
        S_IDLE: begin
          // A stale sd_ack here has no effect; only requests move us on.
          if (w_pick_valid) begin
            r_grant_id    <= w_pick_idx;
            r_sd_lba      <= req_lba[w_pick_idx];
            r_sd_blk_cnt  <= req_blk_cnt[w_pick_idx];
            // Read wins when both are pending; the write waits its turn.
            r_sd_rd       <= req_rd[w_pick_idx];
            r_sd_wr       <= ~req_rd[w_pick_idx];
            r_timeout_cnt <= '0;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_state <= S_XFER;
          end else if (r_timeout_cnt == 32'(TIMEOUT - 1)) begin
            r_sd_rd                <= 1'b0;
            r_sd_wr                <= 1'b0;
            r_req_err[r_grant_id]  <= 1'b1;
            r_state                <= S_DONE;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 32'd1;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            r_req_ack[r_grant_id] <= 1'b1;
            r_state               <= S_DONE;
          end
        end
        S_DONE: begin
          r_last_grant <= r_grant_id;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Forward the SD write strobe only to the current owner during XFER.
  // NOTE: the output gets a default before any conditional assignment so the
  // block stays combinational and never infers a latch.
  always_comb begin
    req_buff_wr = '0;
    if (r_state == S_XFER) begin
      req_buff_wr[r_grant_id] = sd_buff_wr;
    end
  end

  assign sd_buff_din = req_buff_din[r_grant_id];
  assign sd_lba      = r_sd_lba;
  assign sd_blk_cnt  = r_sd_blk_cnt;
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign req_ack     = r_req_ack;
  assign req_err     = r_req_err;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter. The reference model tracks pending
// requests and the last owner, and derives every expected grant, field value
// and pulse from the round-robin / read-before-write rules.
module tb_sd_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(NREQ);

  logic            clk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_rd, req_wr;
  logic [31:0]     req_lba      [NREQ];
  logic [5:0]      req_blk_cnt  [NREQ];
  logic [7:0]      req_buff_din [NREQ];
  logic [NREQ-1:0] req_buff_wr, req_ack, req_err;
  logic [31:0]     sd_lba;
  logic [5:0]      sd_blk_cnt;
  logic            sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]      sd_buff_din;
  logic            busy;
  logic [IW-1:0]   grant_id;

  int errors = 0;
  int checks = 0;
  int m_last;

  sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .req_blk_cnt  (req_blk_cnt),
    .req_buff_din (req_buff_din),
    .req_buff_wr  (req_buff_wr),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Next owner: first pending requester after the last one, wrapping.
  function automatic int model_next(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_lba[i]      = $urandom;
      req_blk_cnt[i]  = 6'($urandom);
      req_buff_din[i] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last = NREQ - 1;
  endtask

  // Serve one transaction as the SD side, checking the whole handshake.
  task automatic run_txn(input int exp_id, input int ack_delay, input int ack_hold,
                         output int waited);
    logic            exp_wr;
    logic [31:0]     exp_lba;
    logic [5:0]      exp_cnt;
    logic [NREQ-1:0] exp_bit;
    exp_wr  = !req_rd[exp_id];
    exp_lba = req_lba[exp_id];
    exp_cnt = req_blk_cnt[exp_id];
    exp_bit = NREQ'(1) << exp_id;
    waited  = 0;
    while (!(sd_rd || sd_wr) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!(sd_rd || sd_wr)) begin
      errors++;
      $display("FAIL issue_wait no sd_rd/sd_wr after %0d cycles, expected owner %0d", waited, exp_id);
      return;
    end
    checks++;
    if (grant_id !== IW'(exp_id) || sd_lba !== exp_lba || sd_blk_cnt !== exp_cnt ||
        sd_wr !== exp_wr || sd_rd !== !exp_wr || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_fields got id=%0d lba=%h cnt=%0d rd=%b wr=%b busy=%b, expected id=%0d lba=%h cnt=%0d rd=%b wr=%b busy=1",
               grant_id, sd_lba, sd_blk_cnt, sd_rd, sd_wr, busy, exp_id, exp_lba, exp_cnt, !exp_wr, exp_wr);
    end
    for (int i = 0; i < ack_delay; i++) begin
      scramble_inputs();
      sd_buff_wr = 1'b1;
      #1;
      checks++;
      if (req_buff_wr !== '0) begin
        errors++;
        $display("FAIL issue_gate req_buff_wr=%b outside XFER, expected 0", req_buff_wr);
      end
      @(negedge clk);
      checks++;
      if ({sd_rd, sd_wr} !== {!exp_wr, exp_wr} || sd_lba !== exp_lba || sd_blk_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL issue_hold got rd=%b wr=%b lba=%h cnt=%0d, expected rd=%b wr=%b lba=%h cnt=%0d",
                 sd_rd, sd_wr, sd_lba, sd_blk_cnt, !exp_wr, exp_wr, exp_lba, exp_cnt);
      end
    end
    sd_ack = 1'b1;
    sd_buff_wr = 1'b0;
    scramble_inputs();
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL xfer_entry got rd=%b wr=%b busy=%b, expected rd=0 wr=0 busy=1", sd_rd, sd_wr, busy);
    end
    for (int i = 1; i <= ack_hold; i++) begin
      scramble_inputs();
      sd_buff_wr = 1'($urandom);
      if (i == ack_hold) sd_ack = 1'b0;
      #1;
      checks++;
      if (req_buff_wr !== (sd_buff_wr ? exp_bit : '0) || sd_buff_din !== req_buff_din[exp_id] ||
          sd_lba !== exp_lba || sd_blk_cnt !== exp_cnt || req_ack !== '0) begin
        errors++;
        $display("FAIL xfer_gate got bwr=%b din=%h lba=%h cnt=%0d ack=%b, expected bwr=%b din=%h lba=%h cnt=%0d ack=0",
                 req_buff_wr, sd_buff_din, sd_lba, sd_blk_cnt, req_ack,
                 (sd_buff_wr ? exp_bit : '0), req_buff_din[exp_id], exp_lba, exp_cnt);
      end
      @(negedge clk);
    end
    sd_buff_wr = 1'b0;
    checks++;
    if (req_ack !== exp_bit || req_err !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got ack=%b err=%b busy=%b, expected ack=%b err=0 busy=1",
               req_ack, req_err, busy, exp_bit);
    end
    if (exp_wr) req_wr[exp_id] = 1'b0;
    else        req_rd[exp_id] = 1'b0;
    m_last = exp_id;
    @(negedge clk);
    checks++;
    if (req_ack !== '0 || req_err !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_single got ack=%b err=%b busy=%b, expected ack=0 err=0 busy=0", req_ack, req_err, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || grant_id !== '0 ||
        sd_lba !== '0 || sd_blk_cnt !== '0 || req_ack !== '0 || req_err !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b rd=%b wr=%b id=%0d lba=%h cnt=%0d ack=%b err=%b, expected all 0",
               busy, sd_rd, sd_wr, grant_id, sd_lba, sd_blk_cnt, req_ack, req_err);
    end
  endtask

  task automatic test_single_read();
    int w;
    // Stale ack with no request must leave the arbiter idle.
    sd_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || req_ack !== '0) begin
      errors++;
      $display("FAIL stale_ack got busy=%b rd=%b ack=%b, expected 0", busy, sd_rd, req_ack);
    end
    sd_ack = 1'b0;
    req_lba[2] = 32'h10;
    req_rd[2]  = 1'b1;
    run_txn(model_next(req_rd | req_wr, m_last), 2, 4, w);
  endtask

  task automatic test_contention();
    int w;
    do_reset();
    scramble_inputs();
    req_rd = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      int exp;
      exp = model_next(req_rd | req_wr, m_last);
      checks++;
      if (exp !== (n == 2 ? 3 : n)) begin
        errors++;
        $display("FAIL contention_order model owner=%0d at step %0d", exp, n);
      end
      run_txn(exp, 1, 2, w);
    end
  endtask

  task automatic test_write_gating();
    int w;
    do_reset();
    scramble_inputs();
    req_wr[1] = 1'b1;
    run_txn(model_next(req_rd | req_wr, m_last), 3, 6, w);
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_rd[0] = 1'b1;
    n = 0;
    while (!sd_rd && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (sd_rd && n < 100) begin
      if (req_ack !== '0 || req_err !== '0) begin
        checks++;
        errors++;
        $display("FAIL timeout_early got ack=%b err=%b while issuing", req_ack, req_err);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len sd_rd high %0d cycles, expected %0d", n, TIMEOUT);
    end
    checks++;
    if (req_err !== 4'b0001 || req_ack !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse got err=%b ack=%b busy=%b, expected err=0001 ack=0 busy=1", req_err, req_ack, busy);
    end
    req_rd[0] = 1'b0;
    m_last = 0;
    @(negedge clk);
    checks++;
    if (req_err !== '0 || req_ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_single got err=%b ack=%b busy=%b, expected 0", req_err, req_ack, busy);
    end
  endtask

  task automatic test_reset_xfer();
    int n;
    do_reset();
    req_lba[1] = 32'hABCD;
    req_rd[1]  = 1'b1;
    n = 0;
    while (!sd_rd && n < 10) begin @(negedge clk); n++; end
    sd_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_xfer_setup got busy=%b rd=%b, expected busy=1 rd=0", busy, sd_rd);
    end
    reset = 1'b1; req_rd = '0; sd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0 || req_ack !== '0 || req_err !== '0 ||
        sd_lba !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL rst_xfer got rd=%b wr=%b busy=%b ack=%b err=%b lba=%h id=%0d, expected all 0",
               sd_rd, sd_wr, busy, req_ack, req_err, sd_lba, grant_id);
    end
    reset = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk);
    checks++;
    if (req_ack !== '0 || req_err !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_xfer_after got ack=%b err=%b busy=%b, expected 0", req_ack, req_err, busy);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    scramble_inputs();
    req_rd[3] = 1'b1;
    req_wr[3] = 1'b1;
    run_txn(model_next(req_rd | req_wr, m_last), 0, 2, w);
    checks++;
    if (req_wr[3] !== 1'b1 || req_rd[3] !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_model read not served first");
    end
    run_txn(model_next(req_rd | req_wr, m_last), 1, 3, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL back_to_back gap=%0d cycles, expected 1", w);
    end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    scramble_inputs();
    for (int n = 0; n < 30; n++) begin
      if ((req_rd | req_wr) == '0 || $urandom_range(0, 2) == 0) begin
        req_rd = req_rd | NREQ'($urandom);
        req_wr = req_wr | NREQ'($urandom);
        if ((req_rd | req_wr) == '0) req_wr[$urandom_range(0, NREQ - 1)] = 1'b1;
      end
      run_txn(model_next(req_rd | req_wr, m_last), $urandom_range(0, 3), $urandom_range(1, 4), w);
    end
  endtask

  initial begin
    reset = 1'b1; req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_lba[i] = '0; req_blk_cnt[i] = '0; req_buff_din[i] = '0;
    end
    m_last = NREQ - 1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_gating();
    test_timeout();
    test_reset_xfer();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (FDD drives).
REQ-002 SHALL have parameter TIMEOUT, default 2097152, cycles to wait for sd_ack rise before abort.
REQ-003 SHALL have port clk  in  1  system clock; the block uses one clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_rd / req_wr  in  NREQ  per-requester level requests, held until req_ack.
REQ-006 SHALL have port req_lba[0:NREQ-1]  in  32 each  requested block address.
REQ-007 SHALL have port req_blk_cnt[0:NREQ-1]  in  6 each  block count minus one.
REQ-008 SHALL have port req_buff_din[0:NREQ-1]  in  8 each  requester write data toward SD.
REQ-009 SHALL have port req_buff_wr  out  NREQ  sd_buff_wr gated to the granted requester only.
REQ-010 SHALL have ports req_ack / req_err  out  NREQ  one-cycle completion / timeout pulses.
REQ-011 SHALL have ports sd_lba  out  32, sd_blk_cnt  out  6, sd_rd / sd_wr  out  1, sd_ack  in  1, sd_buff_wr  in  1, sd_buff_din  out  8: the single shared SD channel.
REQ-012 SHALL have ports busy  out  1 and grant_id  out  $clog2(NREQ)  current owner.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> XFER -> DONE -> IDLE.
REQ-014 IDLE: if any req_rd|req_wr is high, SHALL pick a requester round-robin starting at last_grant+1, register grant_id, sd_lba, sd_blk_cnt and the op, then go to ISSUE; if none, stay in IDLE.
REQ-015 If the picked requester has both req_rd and req_wr high, SHALL serve the read; the write remains pending.
REQ-016 ISSUE: SHALL hold sd_rd (read) or sd_wr (write) high; on sd_ack=1, SHALL drop sd_rd/sd_wr in the same edge and go to XFER.
REQ-017 ISSUE: SHALL count cycles; when the count reaches TIMEOUT, SHALL drop sd_rd/sd_wr, set the error flag, and go to DONE.
REQ-018 XFER: SHALL stay while sd_ack=1; on sd_ack=0, SHALL go to DONE.
REQ-019 DONE: lasts exactly one cycle; SHALL assert req_ack[grant_id], or req_err[grant_id] instead if timed out; SHALL set last_grant=grant_id; next state IDLE.
REQ-020 Requesters drop their request on the edge that samples req_ack/req_err; the arbiter SHALL NOT re-grant in the DONE cycle.
REQ-021 sd_lba, sd_blk_cnt and the op SHALL remain stable from ISSUE entry to DONE exit, regardless of requester input changes.
REQ-022 req_buff_wr SHALL equal sd_buff_wr on bit grant_id only while in XFER, and be 0 otherwise (combinational).
REQ-023 sd_buff_din SHALL equal req_buff_din[grant_id] (combinational); its value outside XFER is don't-care.
REQ-024 sd_ack=1 while in IDLE (stale ack) SHALL be ignored.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Round-robin SHALL wrap from requester NREQ-1 to 0; with one active requester, it is served back-to-back with one idle cycle between transactions.

Reset
REQ-027 On reset, regardless of state, SHALL set: state=IDLE; sd_rd=sd_wr=0; req_ack=req_err=0; sd_lba=0; sd_blk_cnt=0; grant_id=0; last_grant=NREQ-1; timeout counter=0; busy=0.
REQ-028 Reset mid-transaction SHALL drop sd_rd/sd_wr on the reset edge and SHALL NOT pulse req_ack or req_err.

Structure
REQ-029 Package sd_arb_pkg SHALL hold the FSM state enum, the default TIMEOUT value and the SD field widths (LBA=32, BLKCNT=6).
REQ-030 Sub-module rr_pick (NREQ-bit request vector plus last grant in; valid and index out, combinational) SHALL implement the round-robin selection.

Verification
REQ-031 Single read: req_rd[2]=1, req_lba[2]=0x10. Required: sd_rd=1 with sd_lba=0x10; ack held 4 cycles; then req_ack[2] pulses exactly 1 cycle.
REQ-032 Contention: req_rd=4'b1011 simultaneously after reset. Required: grant order 0, 1, 3, and each sd_lba matches its owner.
REQ-033 Write gating: grant requester 1 for write with sd_buff_wr toggling during XFER. Required: only req_buff_wr[1] follows it, and sd_buff_din equals req_buff_din[1].
REQ-034 Timeout (TIMEOUT=16): sd_ack never rises. Required: sd_rd drops after 16 cycles, req_err[0] pulses, req_ack stays 0.
REQ-035 Reset in XFER. Required: sd_rd=sd_wr=0 and busy=0 the next cycle, with no ack/err pulse.
REQ-036 Both req_rd[3] and req_wr[3] set. Required: read served first, then write as a separate transaction.
